// File: rtl/clock_set_ctrl_pkg.sv
// Shared clock package: field select codes, field limits, edit FSM states
// and the selection-stepping helper.
package clock_set_ctrl_pkg;

  // Field select codes as presented on o_sel
  localparam logic [1:0] SEL_SS = 2'd0;
  localparam logic [1:0] SEL_MM = 2'd1;
  localparam logic [1:0] SEL_HH = 2'd2;

  // Largest legal value of each time field
  localparam logic [5:0] MAX_SS = 6'd59;
  localparam logic [5:0] MAX_MM = 6'd59;
  localparam logic [4:0] MAX_HH = 5'd23;

  // Edit controller states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_e;

  // Step the field selection: up moves toward hours (0->1->2->0),
  // down moves toward seconds (0->2->1->0). The unused code 3 recovers to minutes.
  function automatic logic [1:0] sel_step(input logic [1:0] sel, input logic up);
    logic [1:0] nxt;
    case (sel)
      SEL_SS:  nxt = up ? SEL_MM : SEL_HH;
      SEL_MM:  nxt = up ? SEL_HH : SEL_SS;
      SEL_HH:  nxt = up ? SEL_SS : SEL_MM;
      default: nxt = SEL_MM;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_mod_updown.sv
// Wrap-around increment/decrement of a single time field. Purely
// combinational; the caller registers the result.
module mod_updown #(
  parameter int             W   = 6,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  // Next field value: inc wraps MAX->0, dec wraps 0->MAX, both or neither holds
  always_comb begin
    o_val = i_val;
    if (i_inc && !i_dec) begin
      // Out-of-range values also wrap to zero so the field self-heals
      if (i_val >= MAX) begin
        o_val = ZERO;
      end else begin
        o_val = i_val + ONE;
      end
    end else if (i_dec && !i_inc) begin
      if ((i_val == ZERO) || (i_val > MAX)) begin
        o_val = MAX;
      end else begin
        o_val = i_val - ONE;
      end
    end else begin
      o_val = i_val;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit-mode controller for the clock: snapshots the running time on a
// write pulse, lets the user adjust one field at a time, and commits the
// edited value with a one-cycle load strobe. Idle sessions time out.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_wr_pulse,
  input  logic       i_val_inc_pulse,
  input  logic       i_val_dec_pulse,
  input  logic       i_sel_inc_pulse,
  input  logic       i_sel_dec_pulse,
  input  logic [4:0] i_hh,
  input  logic [5:0] i_mm,
  input  logic [5:0] i_ss,
  output logic       o_editing,
  output logic [1:0] o_sel,
  output logic [4:0] o_edit_hh,
  output logic [5:0] o_edit_mm,
  output logic [5:0] o_edit_ss,
  output logic       o_load,
  output logic       o_blink
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic [1:0] sel_q,   sel_d;
  logic [4:0] hh_q,    hh_d;
  logic [5:0] mm_q,    mm_d;
  logic [5:0] ss_q,    ss_d;
  logic       load_q,  load_d;
  logic       blink_q, blink_d;
  logic [7:0] tcnt_q,  tcnt_d;

  logic       any_pulse;
  logic       sel_act;
  logic       val_act;
  logic       val_en;
  logic [4:0] hh_nxt;
  logic [5:0] mm_nxt;
  logic [5:0] ss_nxt;

  // A pair pulsed together cancels out, leaving the lower-priority pair free
  assign any_pulse = i_wr_pulse | i_val_inc_pulse | i_val_dec_pulse
                   | i_sel_inc_pulse | i_sel_dec_pulse;
  assign sel_act   = i_sel_inc_pulse ^ i_sel_dec_pulse;
  assign val_act   = i_val_inc_pulse ^ i_val_dec_pulse;
  assign val_en    = (state_q == ST_EDIT) && !i_wr_pulse && !sel_act && val_act;

  mod_updown #(.W(5), .MAX(MAX_HH)) u_hh (
    .i_val (hh_q),
    .i_inc (val_en && i_val_inc_pulse && (sel_q == SEL_HH)),
    .i_dec (val_en && i_val_dec_pulse && (sel_q == SEL_HH)),
    .o_val (hh_nxt)
  );

  mod_updown #(.W(6), .MAX(MAX_MM)) u_mm (
    .i_val (mm_q),
    .i_inc (val_en && i_val_inc_pulse && (sel_q == SEL_MM)),
    .i_dec (val_en && i_val_dec_pulse && (sel_q == SEL_MM)),
    .o_val (mm_nxt)
  );

  mod_updown #(.W(6), .MAX(MAX_SS)) u_ss (
    .i_val (ss_q),
    .i_inc (val_en && i_val_inc_pulse && (sel_q == SEL_SS)),
    .i_dec (val_en && i_val_dec_pulse && (sel_q == SEL_SS)),
    .o_val (ss_nxt)
  );

  // Next-state logic: entry snapshot, commit, selection/value edits and timeout
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hh_d    = hh_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    load_d  = 1'b0;
    blink_d = blink_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      ST_RUN: begin
        if (i_wr_pulse) begin
          state_d = ST_EDIT;
          hh_d    = i_hh;
          mm_d    = i_mm;
          ss_d    = i_ss;
          sel_d   = SEL_MM;
          tcnt_d  = 8'd0;
          blink_d = 1'b0;
        end else begin
          blink_d = 1'b0;
        end
      end

      ST_EDIT: begin
        if (i_wr_pulse) begin
          // Commit: edit registers keep their values through the load cycle
          state_d = ST_RUN;
          load_d  = 1'b1;
          blink_d = 1'b0;
          tcnt_d  = 8'd0;
        end else begin
          hh_d = hh_nxt;
          mm_d = mm_nxt;
          ss_d = ss_nxt;

          if (sel_act) begin
            sel_d = sel_step(sel_q, i_sel_inc_pulse);
          end else begin
            sel_d = sel_q;
          end

          if (i_tick) begin
            blink_d = ~blink_q;
          end else begin
            blink_d = blink_q;
          end

          // Any pulse, even a dropped one, counts as activity and beats a tick
          if (any_pulse) begin
            tcnt_d = 8'd0;
          end else if (i_tick) begin
            if ((tcnt_q + 8'd1) >= TIMEOUT_LIM) begin
              state_d = ST_RUN;
              tcnt_d  = 8'd0;
              blink_d = 1'b0;
            end else begin
              tcnt_d = tcnt_q + 8'd1;
            end
          end else begin
            tcnt_d = tcnt_q;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
        sel_d   = SEL_MM;
        blink_d = 1'b0;
        tcnt_d  = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      sel_q   <= SEL_MM;
      hh_q    <= 5'd0;
      mm_q    <= 6'd0;
      ss_q    <= 6'd0;
      load_q  <= 1'b0;
      blink_q <= 1'b0;
      tcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      load_q  <= load_d;
      blink_q <= blink_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign o_editing = (state_q == ST_EDIT);
  assign o_sel     = sel_q;
  assign o_edit_hh = hh_q;
  assign o_edit_mm = mm_q;
  assign o_edit_ss = ss_q;
  assign o_load    = load_q;
  assign o_blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: each driven cycle pushes the
// reference model's expected outputs; a monitor pops and compares them
// one cycle later.
module tb_clock_set_ctrl;

  localparam int TO = 3;

  localparam logic [6:0] P_RST = 7'b1000000;
  localparam logic [6:0] P_WR  = 7'b0100000;
  localparam logic [6:0] P_VI  = 7'b0010000;
  localparam logic [6:0] P_VD  = 7'b0001000;
  localparam logic [6:0] P_SI  = 7'b0000100;
  localparam logic [6:0] P_SD  = 7'b0000010;
  localparam logic [6:0] P_TK  = 7'b0000001;
  localparam logic [6:0] P_NO  = 7'b0000000;

  typedef struct packed {
    logic       editing;
    logic [1:0] sel;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic       load;
    logic       blink;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, wr = 1'b0, vi = 1'b0, vd = 1'b0, si = 1'b0, sd = 1'b0;
  logic [4:0] hh_in = 5'd0;
  logic [5:0] mm_in = 6'd0, ss_in = 6'd0;
  logic       editing, load, blink;
  logic [1:0] sel;
  logic [4:0] ehh;
  logic [5:0] emm, ess;

  int checks = 0;
  int errors = 0;
  obs_t exp_q[$];

  // Reference model state: fields indexed 0 = seconds, 1 = minutes, 2 = hours
  bit m_edit = 1'b0, m_load = 1'b0, m_blink = 1'b0;
  int m_sel = 1, m_cnt = 0;
  int m_f[3] = '{0, 0, 0};
  int m_max[3] = '{59, 59, 23};
  int t_hh = 0, t_mm = 0, t_ss = 0;

  clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_tick          (tick),
    .i_wr_pulse      (wr),
    .i_val_inc_pulse (vi),
    .i_val_dec_pulse (vd),
    .i_sel_inc_pulse (si),
    .i_sel_dec_pulse (sd),
    .i_hh            (hh_in),
    .i_mm            (mm_in),
    .i_ss            (ss_in),
    .o_editing       (editing),
    .o_sel           (sel),
    .o_edit_hh       (ehh),
    .o_edit_mm       (emm),
    .o_edit_ss       (ess),
    .o_load          (load),
    .o_blink         (blink)
  );

  always #5 clk = ~clk;

  // Advance the reference model by one clock using the rules of the edit session
  task automatic model_step(input logic [6:0] p);
    bit act;
    int f;
    act = p[5] | p[4] | p[3] | p[2] | p[1];
    m_load = 1'b0;
    if (p[6]) begin
      m_edit = 1'b0; m_sel = 1; m_f = '{0, 0, 0}; m_blink = 1'b0; m_cnt = 0;
    end else if (!m_edit) begin
      if (p[5]) begin
        m_edit = 1'b1; m_sel = 1; m_cnt = 0; m_blink = 1'b0;
        m_f[0] = t_ss; m_f[1] = t_mm; m_f[2] = t_hh;
      end
    end else if (p[5]) begin
      m_edit = 1'b0; m_load = 1'b1; m_blink = 1'b0; m_cnt = 0;
    end else begin
      if (p[2] != p[1]) begin
        m_sel = p[2] ? (m_sel + 1) % 3 : (m_sel + 2) % 3;
      end else if (p[4] != p[3]) begin
        f = m_sel;
        m_f[f] = p[4] ? (m_f[f] + 1) % (m_max[f] + 1)
                      : (m_f[f] + m_max[f]) % (m_max[f] + 1);
      end
      if (p[0]) m_blink = !m_blink;
      if (act) m_cnt = 0;
      else if (p[0]) m_cnt = m_cnt + 1;
      if (m_cnt == TO) begin
        m_edit = 1'b0; m_blink = 1'b0; m_cnt = 0;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic cyc(input logic [6:0] p);
    obs_t e;
    @(negedge clk);
    rst = p[6]; wr = p[5]; vi = p[4]; vd = p[3]; si = p[2]; sd = p[1]; tick = p[0];
    hh_in = 5'(t_hh); mm_in = 6'(t_mm); ss_in = 6'(t_ss);
    model_step(p);
    e.editing = m_edit;
    e.sel     = 2'(m_sel);
    e.hh      = 5'(m_f[2]);
    e.mm      = 6'(m_f[1]);
    e.ss      = 6'(m_f[0]);
    e.load    = m_load;
    e.blink   = m_blink;
    exp_q.push_back(e);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_hh = h; t_mm = m; t_ss = s;
  endtask

  // Monitor: compare every registered output set just after each edge
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{editing, sel, ehh, emm, ess, load, blink};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got ed=%0b sel=%0d %0d:%0d:%0d load=%0b blink=%0b, want ed=%0b sel=%0d %0d:%0d:%0d load=%0b blink=%0b",
                 $time, a.editing, a.sel, a.hh, a.mm, a.ss, a.load, a.blink,
                 e.editing, e.sel, e.hh, e.mm, e.ss, e.load, e.blink);
      end
    end
  end

  initial begin
    logic [6:0] p;
    int wait_n;

    // Reset state
    cyc(P_RST); cyc(P_RST);

    // Snapshot and commit
    set_time(12, 34, 56);
    cyc(P_NO); cyc(P_WR); cyc(P_NO);
    set_time(1, 2, 3);               // ignored while editing
    cyc(P_NO); cyc(P_WR); cyc(P_NO); cyc(P_NO);

    // Wrap cases and selection stepping
    set_time(0, 59, 10);
    cyc(P_WR); cyc(P_VI); cyc(P_SI); cyc(P_VD);
    cyc(P_SI); cyc(P_SD); cyc(P_SD);
    cyc(P_SD); cyc(P_VD); cyc(P_SD); cyc(P_SD); cyc(P_VI);

    // Same-cycle pulses
    cyc(P_TK); cyc(P_TK); cyc(P_VI | P_VD); cyc(P_TK); cyc(P_TK);
    cyc(P_SI | P_VI); cyc(P_SI | P_SD | P_VD);
    cyc(P_WR | P_VI); cyc(P_NO);

    // Timeout with no activity
    set_time(7, 8, 9);
    cyc(P_WR); cyc(P_TK); cyc(P_NO); cyc(P_TK); cyc(P_TK); cyc(P_NO); cyc(P_NO);

    // Activity between tick 2 and tick 3 keeps the session alive
    cyc(P_WR); cyc(P_TK); cyc(P_TK); cyc(P_VI); cyc(P_TK); cyc(P_NO);
    cyc(P_TK); cyc(P_VI | P_TK); cyc(P_TK); cyc(P_TK); cyc(P_TK); cyc(P_NO);

    // Reset during edit, and reset together with commit
    cyc(P_WR); cyc(P_VI); cyc(P_SI); cyc(P_VD); cyc(P_RST); cyc(P_NO);
    cyc(P_WR); cyc(P_VI); cyc(P_RST | P_WR); cyc(P_NO);

    // RUN ignores edits and ticks; EDIT blinks on ticks
    cyc(P_VI | P_SI | P_TK); cyc(P_TK); cyc(P_VD | P_SD);
    cyc(P_WR); cyc(P_TK); cyc(P_TK); cyc(P_NO); cyc(P_WR); cyc(P_TK);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      p = P_NO;
      if ($urandom_range(0, 299) == 0) p = p | P_RST;
      if ($urandom_range(0, 11) == 0)  p = p | P_WR;
      if ($urandom_range(0, 5) == 0)   p = p | P_VI;
      if ($urandom_range(0, 5) == 0)   p = p | P_VD;
      if ($urandom_range(0, 5) == 0)   p = p | P_SI;
      if ($urandom_range(0, 5) == 0)   p = p | P_SD;
      if ($urandom_range(0, 2) == 0)   p = p | P_TK;
      cyc(p);
    end
    cyc(P_NO); cyc(P_NO);

    // Drain the scoreboard within a bounded number of cycles
    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
